// File: rtl/vga_pkg.sv
// Shared timing defaults, sync polarity constants and the 8x8 Bayer threshold helper.
package vga_pkg;

    // Default 1526 x 525 timing (48 MHz pixel clock)
    localparam int unsigned H_DISPLAY_DEF = 1220;
    localparam int unsigned H_FRONT_DEF   = 31;
    localparam int unsigned H_SYNC_DEF    = 183;
    localparam int unsigned H_BACK_DEF    = 92;
    localparam int unsigned V_DISPLAY_DEF = 480;
    localparam int unsigned V_FRONT_DEF   = 10;
    localparam int unsigned V_SYNC_DEF    = 2;
    localparam int unsigned V_BACK_DEF    = 33;

    localparam int unsigned H_CNT_W       = 11;
    localparam int unsigned V_CNT_W       = 10;
    localparam int unsigned BAYER_W       = 6;

    localparam logic SYNC_ACTIVE_LOW  = 1'b0;
    localparam logic SYNC_ACTIVE_HIGH = 1'b1;

    // Bit-interleaved 8x8 ordered-dither threshold, MSB first
    function automatic logic [BAYER_W-1:0] bayer6(input logic [2:0] i, input logic [2:0] j);
        return {i[0] ^ j[0], i[0], i[1] ^ j[1], i[1], i[2] ^ j[2], i[2]};
    endfunction

endpackage

// File: rtl/bayer_dither.sv
// Single-channel ordered dither: reduces IN_BITS to OUT_BITS using the Bayer threshold
// at cell (i,j); rounds up when the dropped fraction exceeds the threshold, saturating.
module bayer_dither
    import vga_pkg::*;
#(
    parameter int unsigned IN_BITS  = 6,
    parameter int unsigned OUT_BITS = 1
) (
    input  logic [IN_BITS-1:0]  pix_i,
    input  logic [2:0]          i_i,
    input  logic [2:0]          j_i,
    output logic [OUT_BITS-1:0] pix_o
);

    localparam int unsigned R = IN_BITS - OUT_BITS;

    logic [OUT_BITS-1:0] q;
    logic [OUT_BITS:0]   q_inc;
    logic [R-1:0]        frac;
    logic [R-1:0]        thr;
    logic [BAYER_W-1:0]  b6;

    // Split colour into kept part and dropped fraction; threshold is the top R Bayer bits
    always_comb begin
        q     = pix_i[IN_BITS-1:R];
        frac  = pix_i[R-1:0];
        b6    = bayer6(i_i, j_i);
        thr   = R'(b6 >> (BAYER_W - R));
        q_inc = {1'b0, q} + {{OUT_BITS{1'b0}}, 1'b1};
        pix_o = q;
        if (frac > thr) begin
            pix_o = q_inc[OUT_BITS] ? {OUT_BITS{1'b1}} : q_inc[OUT_BITS-1:0];
        end
    end

endmodule

// File: rtl/vga_scanout.sv
// VGA scan-out engine: H/V/frame counters, scheduling strobes, registered syncs and
// Bayer-dithered colour. Define VGA_TEMPORAL_DITHER_EN to rotate the dither pattern
// over four frames.
module vga_scanout
    import vga_pkg::*;
#(
    parameter int unsigned H_DISPLAY  = H_DISPLAY_DEF,
    parameter int unsigned H_FRONT    = H_FRONT_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BACK     = H_BACK_DEF,
    parameter int unsigned V_DISPLAY  = V_DISPLAY_DEF,
    parameter int unsigned V_FRONT    = V_FRONT_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BACK     = V_BACK_DEF,
    parameter logic        SYNC_POL   = SYNC_ACTIVE_LOW,
    parameter int unsigned IN_BITS    = 6,
    parameter int unsigned OUT_BITS   = 1,
    parameter int unsigned PREFETCH   = 16,
    parameter int unsigned FRAME_BITS = 11
) (
    input  logic                  clk48,
    input  logic                  rst,
    input  logic                  pause_n,
    input  logic [IN_BITS-1:0]    pix_r,
    input  logic [IN_BITS-1:0]    pix_g,
    input  logic [IN_BITS-1:0]    pix_b,
    output logic [H_CNT_W-1:0]    h_count,
    output logic [V_CNT_W-1:0]    v_count,
    output logic [FRAME_BITS-1:0] frame,
    output logic                  active,
    output logic                  prefetch,
    output logic                  line_end,
    output logic                  frame_end,
    output logic                  hsync,
    output logic                  vsync,
    output logic [OUT_BITS-1:0]   r_out,
    output logic [OUT_BITS-1:0]   g_out,
    output logic [OUT_BITS-1:0]   b_out
);

    localparam int unsigned H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned HS_START   = H_DISPLAY + H_FRONT;
    localparam int unsigned HS_END     = HS_START + H_SYNC;
    localparam int unsigned VS_START   = V_DISPLAY + V_FRONT;
    localparam int unsigned VS_END     = VS_START + V_SYNC;

    logic [H_CNT_W-1:0]    h_q, h_d;
    logic [V_CNT_W-1:0]    v_q, v_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic                  hs_q, hs_d;
    logic                  vs_q, vs_d;
    logic [OUT_BITS-1:0]   r_q, r_d;
    logic [OUT_BITS-1:0]   g_q, g_d;
    logic [OUT_BITS-1:0]   b_q, b_d;

    logic                  h_last;
    logic                  v_last;
    logic                  hs_win;
    logic                  vs_win;
    logic [2:0]            di;
    logic [2:0]            dj;
    logic [OUT_BITS-1:0]   r_dith;
    logic [OUT_BITS-1:0]   g_dith;
    logic [OUT_BITS-1:0]   b_dith;

    // Zero-latency position decode used for effect scheduling and the sync windows
    always_comb begin
        h_last    = (h_q == H_CNT_W'(H_TOTAL - 1));
        v_last    = (v_q == V_CNT_W'(V_TOTAL - 1));
        active    = (h_q < H_CNT_W'(H_DISPLAY)) && (v_q < V_CNT_W'(V_DISPLAY));
        prefetch  = (h_q == H_CNT_W'(H_DISPLAY - PREFETCH));
        line_end  = (h_q == H_CNT_W'(H_DISPLAY));
        frame_end = h_last && v_last;
        hs_win    = (h_q >= H_CNT_W'(HS_START)) && (h_q < H_CNT_W'(HS_END));
        vs_win    = (v_q >= V_CNT_W'(VS_START)) && (v_q < V_CNT_W'(VS_END));
    end

    // Next-state for the raster and frame counters; a paused frame holds through wrap
    always_comb begin
        h_d     = h_q + H_CNT_W'(1);
        v_d     = v_q;
        frame_d = frame_q;
        if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + V_CNT_W'(1);
        end
        if (frame_end && pause_n) begin
            frame_d = frame_q + FRAME_BITS'(1);
        end
    end

    // Dither cell coordinates, optionally rotated by the low frame bits
`ifdef VGA_TEMPORAL_DITHER_EN
    always_comb begin
        di = h_q[2:0] ^ {2'b00, frame_q[0]};
        dj = v_q[2:0] + {2'b00, frame_q[1]};
    end
`else
    always_comb begin
        di = h_q[2:0];
        dj = v_q[2:0];
    end
`endif

    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dither_r (
        .pix_i (pix_r),
        .i_i   (di),
        .j_i   (dj),
        .pix_o (r_dith)
    );

    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dither_g (
        .pix_i (pix_g),
        .i_i   (di),
        .j_i   (dj),
        .pix_o (g_dith)
    );

    bayer_dither #(.IN_BITS(IN_BITS), .OUT_BITS(OUT_BITS)) u_dither_b (
        .pix_i (pix_b),
        .i_i   (di),
        .j_i   (dj),
        .pix_o (b_dith)
    );

    // Output stage inputs: blank colour outside the visible area, drive syncs by window
    always_comb begin
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        hs_d = hs_win ? SYNC_POL : ~SYNC_POL;
        vs_d = vs_win ? SYNC_POL : ~SYNC_POL;
        if (active) begin
            r_d = r_dith;
            g_d = g_dith;
            b_d = b_dith;
        end
    end

    // Raster and frame counter registers
    always_ff @(posedge clk48) begin
        if (rst) begin
            h_q     <= '0;
            v_q     <= '0;
            frame_q <= '0;
        end else begin
            h_q     <= h_d;
            v_q     <= v_d;
            frame_q <= frame_d;
        end
    end

    // Colour and sync register stage, one clock behind the counters
    always_ff @(posedge clk48) begin
        if (rst) begin
            r_q  <= '0;
            g_q  <= '0;
            b_q  <= '0;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
        end else begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
        end
    end

    assign h_count = h_q;
    assign v_count = v_q;
    assign frame   = frame_q;
    assign hsync   = hs_q;
    assign vsync   = vs_q;
    assign r_out   = r_q;
    assign g_out   = g_q;
    assign b_out   = b_q;

endmodule

// File: tb/tb_vga_scanout.sv
// Scoreboard bench for vga_scanout: a driver pushes expected post-edge outputs per clock,
// a monitor pops and compares after each edge. Two instances: OUT_BITS=1 and OUT_BITS=2,
// on a reduced 24x12 raster so several frames fit in a short run.
module tb_vga_scanout;

    localparam int HD = 16, HF = 2, HS = 3, HB = 3;
    localparam int VD = 8,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HD + HF + HS + HB;
    localparam int VT = VD + VF + VS + VB;
    localparam int PF = 4;

    typedef struct {
        int h, v, fr, act, pf, le, fe, hs, vs;
        int r1, g1, b1, r2, g2, b2;
    } exp_t;

    typedef struct {
        int f, h, v, pr, pg, pb;
        int r1, g1, b1, r2, g2, b2;
    } tv_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       pause_n;
    logic [5:0] pix_r, pix_g, pix_b;

    logic [10:0] h1, h2;
    logic [9:0]  v1, v2;
    logic [10:0] f1, f2;
    logic        act1, act2, pf1, pf2, le1, le2, fe1, fe2, hs1, hs2, vs1, vs2;
    logic        r1, g1, b1;
    logic [1:0]  r2, g2, b2;

    exp_t exp_q[$];
    tv_t  tv[7];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mh = 0, mv = 0, mf = 0;

    always #5 clk = ~clk;

    vga_scanout #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .IN_BITS(6), .OUT_BITS(1), .PREFETCH(PF), .FRAME_BITS(11)
    ) dut1 (
        .clk48(clk), .rst(rst), .pause_n(pause_n),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .h_count(h1), .v_count(v1), .frame(f1),
        .active(act1), .prefetch(pf1), .line_end(le1), .frame_end(fe1),
        .hsync(hs1), .vsync(vs1), .r_out(r1), .g_out(g1), .b_out(b1)
    );

    vga_scanout #(
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_POL(1'b0), .IN_BITS(6), .OUT_BITS(2), .PREFETCH(PF), .FRAME_BITS(11)
    ) dut2 (
        .clk48(clk), .rst(rst), .pause_n(pause_n),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .h_count(h2), .v_count(v2), .frame(f2),
        .active(act2), .prefetch(pf2), .line_end(le2), .frame_end(fe2),
        .hsync(hs2), .vsync(vs2), .r_out(r2), .g_out(g2), .b_out(b2)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference dither: threshold built from interleaved cell bits, then shifted to R bits
    function automatic int dith(input int pix, input int outb, input int h, input int v, input int f);
        int r, q, fr, i, j, thr6, thr, mx;
        r  = 6 - outb;
        q  = pix >> r;
        fr = pix & ((1 << r) - 1);
        i  = h & 7;
        j  = v & 7;
`ifdef VGA_TEMPORAL_DITHER_EN
        i  = i ^ (f & 1);
        j  = (j + ((f >> 1) & 1)) & 7;
`endif
        thr6 = ((((i) ^ (j)) & 1) << 5) | ((i & 1) << 4)
             | ((((i >> 1) ^ (j >> 1)) & 1) << 3) | (((i >> 1) & 1) << 2)
             | ((((i >> 2) ^ (j >> 2)) & 1) << 1) | ((i >> 2) & 1);
        thr = thr6 >> (6 - r);
        mx  = (1 << outb) - 1;
        if (fr > thr) q = (q + 1 > mx) ? mx : q + 1;
        return q;
    endfunction

    // One clock of stimulus: drive inputs for the current model position, push expectation
    task automatic step(input logic rv, input logic pv);
        exp_t e;
        int   pr, pg, pb, hit;
        bit   vis;
        @(negedge clk);
        rst     = rv;
        pause_n = pv;
        hit     = -1;
        pr = (mh * 5 + mv * 3 + mf) % 64;
        pg = (mh * 11 + mv * 7) % 64;
        pb = (mh * mv + 17) % 64;
        for (int k = 0; k < 7; k++) begin
            if (tv[k].f == mf && tv[k].h == mh && tv[k].v == mv) begin
                hit = k;
                pr  = tv[k].pr; pg = tv[k].pg; pb = tv[k].pb;
            end
        end
        if (hit < 0 && mf == 2) begin
            pr = 63; pg = 63; pb = 63;
        end
        pix_r = 6'(pr);
        pix_g = 6'(pg);
        pix_b = 6'(pb);
        vis = (mh < HD) && (mv < VD);
        if (rv) begin
            mh = 0; mv = 0; mf = 0;
            e.hs = 1; e.vs = 1;
            e.r1 = 0; e.g1 = 0; e.b1 = 0; e.r2 = 0; e.g2 = 0; e.b2 = 0;
        end else begin
            e.hs = (mh >= HD + HF && mh < HD + HF + HS) ? 0 : 1;
            e.vs = (mv >= VD + VF && mv < VD + VF + VS) ? 0 : 1;
            if (hit >= 0) begin
                e.r1 = tv[hit].r1; e.g1 = tv[hit].g1; e.b1 = tv[hit].b1;
                e.r2 = tv[hit].r2; e.g2 = tv[hit].g2; e.b2 = tv[hit].b2;
            end else if (mf == 2) begin
                e.r1 = vis ? 1 : 0; e.g1 = e.r1; e.b1 = e.r1;
                e.r2 = vis ? 3 : 0; e.g2 = e.r2; e.b2 = e.r2;
            end else if (vis) begin
                e.r1 = dith(pr, 1, mh, mv, mf); e.g1 = dith(pg, 1, mh, mv, mf);
                e.b1 = dith(pb, 1, mh, mv, mf);
                e.r2 = dith(pr, 2, mh, mv, mf); e.g2 = dith(pg, 2, mh, mv, mf);
                e.b2 = dith(pb, 2, mh, mv, mf);
            end else begin
                e.r1 = 0; e.g1 = 0; e.b1 = 0; e.r2 = 0; e.g2 = 0; e.b2 = 0;
            end
            if (mh == HT - 1 && mv == VT - 1 && pv) mf = (mf + 1) % 2048;
            if (mh == HT - 1) begin
                mh = 0;
                mv = (mv == VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
        end
        e.h   = mh;
        e.v   = mv;
        e.fr  = mf;
        e.act = (mh < HD && mv < VD) ? 1 : 0;
        e.pf  = (mh == HD - PF) ? 1 : 0;
        e.le  = (mh == HD) ? 1 : 0;
        e.fe  = (mh == HT - 1 && mv == VT - 1) ? 1 : 0;
        exp_q.push_back(e);
    endtask

    // Monitor: every edge that has a pending expectation is checked just after the edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("h_count",   int'(h1),   e.h);
                chk("v_count",   int'(v1),   e.v);
                chk("frame",     int'(f1),   e.fr);
                chk("active",    int'(act1), e.act);
                chk("prefetch",  int'(pf1),  e.pf);
                chk("line_end",  int'(le1),  e.le);
                chk("frame_end", int'(fe1),  e.fe);
                chk("hsync",     int'(hs1),  e.hs);
                chk("vsync",     int'(vs1),  e.vs);
                chk("r_out1",    int'(r1),   e.r1);
                chk("g_out1",    int'(g1),   e.g1);
                chk("b_out1",    int'(b1),   e.b1);
                chk("h_count2",  int'(h2),   e.h);
                chk("v_count2",  int'(v2),   e.v);
                chk("frame2",    int'(f2),   e.fr);
                chk("strobes2",  int'({act2, pf2, le2, fe2}),
                    (e.act << 3) | (e.pf << 2) | (e.le << 1) | e.fe);
                chk("syncs2",    int'({hs2, vs2}), (e.hs << 1) | e.vs);
                chk("r_out2",    int'(r2),   e.r2);
                chk("g_out2",    int'(g2),   e.g2);
                chk("b_out2",    int'(b2),   e.b2);
            end
        end
    end

    // Stimulus: reset, free-run, pause across two frames, release, mid-line reset
    initial begin
        int guard;
        tv[0] = '{0, 0, 0, 32, 63,  0, 1, 1, 0, 2, 3, 0};
        tv[1] = '{0, 1, 0, 31, 16, 63, 1, 0, 1, 2, 1, 3};
        tv[2] = '{0, 2, 1, 23, 22, 60, 1, 0, 1, 1, 1, 3};
        tv[3] = '{0, 20, 0, 63, 63, 63, 0, 0, 0, 0, 0, 0};
        tv[4] = '{0, 5, 8, 63, 63, 63, 0, 0, 0, 0, 0, 0};
`ifdef VGA_TEMPORAL_DITHER_EN
        tv[5] = '{1, 1, 0, 16, 16, 63, 1, 1, 1, 1, 1, 3};
        tv[6] = '{1, 0, 0, 31, 16, 32, 1, 0, 1, 2, 1, 2};
`else
        tv[5] = '{1, 1, 0, 16, 16, 63, 0, 0, 1, 1, 1, 3};
        tv[6] = '{1, 0, 0, 31, 16, 32, 1, 1, 1, 2, 1, 2};
`endif
        rst = 1'b1; pause_n = 1'b1;
        pix_r = '0; pix_g = '0; pix_b = '0;

        repeat (3) step(1'b1, 1'b1);

        guard = 0;
        while (mf < 3 && guard < 2000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        repeat (2 * HT * VT) step(1'b0, 1'b0);
        guard = 0;
        while (mf < 4 && guard < 2000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        repeat (40) step(1'b0, 1'b1);

        guard = 0;
        while (!(mh == 7 && mv == 3) && guard < 2000) begin
            step(1'b0, 1'b1);
            guard++;
        end
        step(1'b1, 1'b1);
        repeat (60) step(1'b0, 1'b1);

        guard = 0;
        while (exp_q.size() != 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        #2;
        chk("scoreboard_drain", exp_q.size(), 0);
        chk("final_frame", int'(f1), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
